// File: rtl/arm_shift_pkg.sv
// Shared definitions for the ARM barrel-shift blocks: FSM states, shift
// saturation limit and the architectural shift-type encodings.
package arm_shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsl_state_e;

    // Any shift of 33 or more gives the same all-zero result and zero carry.
    localparam int MAX_SHIFT = 33;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

endpackage

// File: rtl/logical_shift_left_seq.sv
// Iterative ARM LSL: shifts one bit per cycle, tracking the carry-out as the
// last bit shifted past the MSB. Valid/ready handshake on both sides.
module logical_shift_left_seq
    import arm_shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] shift_data,
    input  logic [7:0]        shift_num,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] shift_out,
    output logic              shift_carry_out
);

    lsl_state_e        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  count_sat;

    // Saturating at 33 keeps the worst-case latency bounded for n up to 255.
    assign count_sat = (shift_num > 8'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT)
                                                   : CNT_W'(shift_num);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d   = shift_data;
                    carry_d = carry_in;
                    count_d = count_sat;
                    state_d = (count_sat == '0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                carry_d = acc_q[DATA_W-1];
                acc_d   = {acc_q[DATA_W-2:0], 1'b0};
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    assign in_ready        = (state_q == ST_IDLE);
    assign out_valid       = (state_q == ST_DONE);
    assign shift_out       = acc_q;
    assign shift_carry_out = carry_q;

endmodule

// File: tb/tb_logical_shift_left_seq.sv
// Scoreboard bench for logical_shift_left_seq: the driver pushes the expected
// LSL result per accepted request, a monitor pops and compares on out_valid.
module tb_logical_shift_left_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] shift_data;
    logic [7:0]  shift_num;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] shift_out;
    logic        shift_carry_out;

    typedef struct {
        logic [31:0] data;
        logic        carry;
        int          latency;
        int          accept_cycle;
    } exp_t;

    exp_t sb[$];
    exp_t front;
    int   tests_run = 0;
    int   fails = 0;
    int   cycle_cnt = 0;
    bit   seen_valid = 0;
    bit   check_ready_next = 0;

    logical_shift_left_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .shift_data      (shift_data),
        .shift_num       (shift_num),
        .carry_in        (carry_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .shift_out       (shift_out),
        .shift_carry_out (shift_carry_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference LSL from the architectural definition using wide arithmetic.
    function automatic exp_t lsl_model(input logic [31:0] d, input int n, input logic c);
        exp_t r;
        logic [63:0] wide;
        r.accept_cycle = 0;
        if (n == 0) begin
            r.data  = d;
            r.carry = c;
        end else if (n <= 32) begin
            wide    = 64'(d) << n;
            r.data  = wide[31:0];
            r.carry = wide[32];
        end else begin
            r.data  = 32'h0;
            r.carry = 1'b0;
        end
        r.latency = (n == 0) ? 1 : ((n > 33) ? 33 : n) + 1;
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic apply_stimulus(input logic [31:0] d, input int n, input logic c);
        exp_t e;
        int   waited = 0;
        shift_data = d;
        shift_num  = 8'(n);
        carry_in   = c;
        in_valid   = 1'b1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            tests_run++;
            fails++;
            $display("[TB] FAIL accept_timeout: in_ready=%0b, required 1", in_ready);
        end else begin
            e = lsl_model(d, n, c);
            e.accept_cycle = cycle_cnt + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        #2;
        check_output("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        #1;
        if (check_ready_next) begin
            check_output("in_ready_after_done", 32'(in_ready), 32'd1);
            check_output("out_valid_after_done", 32'(out_valid), 32'd0);
            check_ready_next = 0;
        end
        if (out_valid) begin
            if (sb.size() == 0) begin
                tests_run++;
                fails++;
                $display("[TB] FAIL unexpected_output: got 0x%08h, required no result", shift_out);
            end else begin
                front = sb[0];
                if (!seen_valid) begin
                    check_output("latency", 32'(cycle_cnt - front.accept_cycle + 1), 32'(front.latency));
                    seen_valid = 1;
                end
                check_output("shift_out", shift_out, front.data);
                check_output("carry_out", 32'(shift_carry_out), 32'(front.carry));
                check_output("in_ready_in_done", 32'(in_ready), 32'd0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen_valid = 0;
                    check_ready_next = 1;
                end
            end
        end
    end

    initial begin
        int n;
        int waited;
        rst        = 1'b1;
        in_valid   = 1'b0;
        shift_data = '0;
        shift_num  = '0;
        carry_in   = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_in_ready", 32'(in_ready), 32'd1);
        check_output("reset_shift_out", shift_out, 32'd0);
        check_output("reset_carry", 32'(shift_carry_out), 32'd0);
        @(negedge clk);

        apply_stimulus(32'h8000_0001, 1, 1'b0);
        wait_drain();
        apply_stimulus(32'h1234_5678, 0, 1'b1);
        wait_drain();
        apply_stimulus(32'h0000_0001, 32, 1'b0);
        wait_drain();
        apply_stimulus(32'h0000_0001, 200, 1'b1);
        wait_drain();
        apply_stimulus(32'hDEAD_BEEF, 33, 1'b1);
        wait_drain();

        // Result held under backpressure; a competing request must be ignored.
        out_ready = 1'b0;
        apply_stimulus(32'hF000_000F, 4, 1'b0);
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_output("hold_reached_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            shift_data = 32'hAAAA_5555;
            shift_num  = 8'd3;
            in_valid   = 1'b1;
            #2;
            check_output("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset during BUSY discards the in-flight n=20 operation.
        apply_stimulus(32'hCAFE_F00D, 20, 1'b1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        seen_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_output("midrst_out_valid", 32'(out_valid), 32'd0);
        check_output("midrst_in_ready", 32'(in_ready), 32'd1);
        check_output("midrst_shift_out", shift_out, 32'd0);
        check_output("midrst_carry", 32'(shift_carry_out), 32'd0);
        repeat (30) @(negedge clk);

        // Back-to-back random requests with the consumer always ready.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0:       n = 0;
                1:       n = $urandom_range(32, 255);
                default: n = $urandom_range(1, 31);
            endcase
            apply_stimulus($urandom, n, 1'($urandom_range(0, 1)));
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
